// File: rtl/capture_pkg.sv
// ============================================================================
// capture_pkg : shared encodings for the capture scheduler
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // trig_sel code that always means "trigger now"; any value >= DATA_W also does
    localparam logic [1:0] TRIG_IMMEDIATE = 2'd3;

    localparam int FRAME_W = 8;

endpackage

`default_nettype wire

// File: rtl/probe_sync.sv
// ============================================================================
// probe_sync : 2-flop synchronizer with delayed copy and edge outputs
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module probe_sync #(
    parameter int DATA_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0] s,
    output logic [DATA_W-1:0] rise,
    output logic [DATA_W-1:0] fall
);

    logic [DATA_W-1:0] meta;
    logic [DATA_W-1:0] s_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            s    <= '0;
            s_d  <= '0;
        end else begin
            meta <= sample_in;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

`default_nettype wire

// File: rtl/capture_scheduler.sv
// ============================================================================
// capture_scheduler : owns the display-RAM write port (clear, arm, capture)
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_scheduler
    import capture_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 3,
    parameter int DIV_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  sample_in,
    input  logic               arm,
    input  logic               clear_req,
    input  logic [1:0]         trig_sel,
    input  logic               trig_rising,
    input  logic               continuous,
    input  logic [DIV_W-1:0]   div,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic [2:0]         state,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_count
);

    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] rise;
    logic [DATA_W-1:0] fall;

    probe_sync #(.DATA_W(DATA_W)) u_probe_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .sample_in (sample_in),
        .s         (s),
        .rise      (rise),
        .fall      (fall)
    );

    state_t             cur_state, nxt_state;
    logic [ADDR_W:0]    ptr, ptr_nxt, ptr_inc;
    logic [DIV_W-1:0]   cnt, cnt_nxt;
    logic [DIV_W-1:0]   div_q, div_q_nxt;
    logic               wr_en_nxt;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    logic [DATA_W-1:0]  wr_data_nxt;
    logic               busy_nxt;
    logic [FRAME_W-1:0] frame_nxt;
    logic               edge_hit;
    logic               immediate;
    logic               trigger;

    // ptr carries one extra bit so reaching 2^ADDR_W is visible without wrap
    assign ptr_inc = ptr + 1'b1;

    always_comb begin
        edge_hit  = 1'b0;
        immediate = (trig_sel == TRIG_IMMEDIATE) || (int'(trig_sel) >= DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(trig_sel) == i) begin
                edge_hit = trig_rising ? rise[i] : fall[i];
            end
        end
        trigger = immediate || edge_hit;
    end

    always_comb begin
        nxt_state   = cur_state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        div_q_nxt   = div_q;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        frame_nxt   = frame_count;

        case (cur_state)
            ST_IDLE: begin
                if (clear_req) begin
                    nxt_state = ST_CLEAR;
                    ptr_nxt   = '0;
                end else if (arm) begin
                    nxt_state = ST_ARMED;
                end
            end
            ST_CLEAR: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = ptr[ADDR_W-1:0];
                wr_data_nxt = '0;
                ptr_nxt     = ptr_inc;
                if (ptr_inc[ADDR_W]) begin
                    nxt_state = ST_IDLE;
                    ptr_nxt   = '0;
                end
            end
            ST_ARMED: begin
                if (clear_req) begin
                    nxt_state = ST_CLEAR;
                    ptr_nxt   = '0;
                end else if (trigger) begin
                    nxt_state = ST_CAPTURE;
                    div_q_nxt = div;
                    ptr_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            ST_CAPTURE: begin
                if (clear_req) begin
                    nxt_state = ST_CLEAR;
                    ptr_nxt   = '0;
                end else if (cnt == '0) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = ptr[ADDR_W-1:0];
                    wr_data_nxt = s;
                    ptr_nxt     = ptr_inc;
                    cnt_nxt     = div_q;
                    if (ptr_inc[ADDR_W]) begin
                        nxt_state = ST_DONE;
                        ptr_nxt   = '0;
                        frame_nxt = frame_count + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                if (clear_req) begin
                    nxt_state = ST_CLEAR;
                    ptr_nxt   = '0;
                end else if (continuous || arm) begin
                    nxt_state = ST_ARMED;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                ptr_nxt   = '0;
            end
        endcase

        busy_nxt = (nxt_state == ST_CLEAR) || (nxt_state == ST_CAPTURE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            div_q       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            cur_state   <= nxt_state;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            div_q       <= div_q_nxt;
            wr_en       <= wr_en_nxt;
            wr_addr     <= wr_addr_nxt;
            wr_data     <= wr_data_nxt;
            busy        <= busy_nxt;
            frame_count <= frame_nxt;
        end
    end

    assign state = cur_state;

endmodule

`default_nettype wire
